stopwatch_ctrl: RTL and testbench

Run-control state machine for the stopwatch, placed between the four debounced push-buttons and the cascaded BCD digit counters.
- Generates the 0.1 s count enable from the system clock.
- Sequences start / pause / stop / clear and produces the clear pulse for the digit counters.
- Provides a lap-hold flag for the display latch and flags counter overflow at 999.9.
- Replaces the free-running prescaler and bare reset wiring in the stopwatch top level.

---
 rtl/stopwatch_ctrl.sv | 130 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run control: button edge detection, start/pause/stop/clear sequencing,
// 0.1 s tick prescaler, lap hold and sticky overflow on digit-chain wrap.
module stopwatch_ctrl #(
    parameter int TICK_DIV     = 5000000,
    parameter int STOP_ON_WRAP = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start_e,
    input  logic       pause_e,
    input  logic       stop_e,
    input  logic       clear_e,
    input  logic       lap_e,
    input  logic       wrap_in,
    output logic       count_en,
    output logic       clr_digits,
    output logic       disp_hold,
    output logic       running,
    output logic       overflow,
    output logic [1:0] state
);

    localparam int            PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic          WRAP_STOP = (STOP_ON_WRAP != 0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        STOPPED = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [4:0]    hist_q;
    logic          count_en_q, count_en_d;
    logic          clr_q, clr_d;
    logic          hold_q, hold_d;
    logic          ovf_q, ovf_d;

    // Bit order {clear, stop, pause, start, lap}; one edge per press.
    logic [4:0] btn_lv;
    logic [4:0] btn_edge;
    logic       wrap_seen;

    assign btn_lv    = {clear_e, stop_e, pause_e, start_e, lap_e};
    assign btn_edge  = btn_lv & ~hist_q;
    assign wrap_seen = count_en_q & wrap_in;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            hist_q     <= '0;
            count_en_q <= 1'b0;
            clr_q      <= 1'b0;
            hold_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            hist_q     <= btn_lv;
            count_en_q <= count_en_d;
            clr_q      <= clr_d;
            hold_q     <= hold_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        count_en_d = 1'b0;
        clr_d      = 1'b0;
        hold_d     = hold_q;
        ovf_d      = ovf_q | wrap_seen;

        if (btn_edge[4]) begin
            state_d = IDLE;
            presc_d = '0;
            clr_d   = 1'b1;
            hold_d  = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (btn_edge[1]) begin
                        state_d = RUN;
                        presc_d = '0;
                    end
                end
                RUN: begin
                    // Leaving RUN freezes the prescaler and suppresses this cycle's tick.
                    if (btn_edge[3] || (wrap_seen && WRAP_STOP)) begin
                        state_d = STOPPED;
                    end else if (btn_edge[2]) begin
                        state_d = PAUSED;
                    end else begin
                        if (btn_edge[0]) hold_d = ~hold_q;
                        if (presc_q == PRESC_MAX) begin
                            presc_d    = '0;
                            count_en_d = 1'b1;
                        end else begin
                            presc_d = presc_q + PW'(1);
                        end
                    end
                end
                PAUSED: begin
                    if (btn_edge[3]) begin
                        state_d = STOPPED;
                    end else if (btn_edge[2] || btn_edge[1]) begin
                        state_d = RUN;
                    end else if (btn_edge[0]) begin
                        hold_d = ~hold_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign count_en   = count_en_q;
    assign clr_digits = clr_q;
    assign disp_hold  = hold_q;
    assign overflow   = ovf_q;
    assign running    = (state_q == RUN);
    assign state      = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios with literal expectations plus
// randomized button/wrap traffic checked every cycle against a behavioural model.
module tb_stopwatch_ctrl;

    localparam int TICK_DIV     = 4;
    localparam int STOP_ON_WRAP = 1;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2, S_STOPPED = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start_e = 1'b0, pause_e = 1'b0, stop_e = 1'b0, clear_e = 1'b0, lap_e = 1'b0;
    logic       wrap_in = 1'b0;
    logic       count_en, clr_digits, disp_hold, running, overflow;
    logic [1:0] state;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .STOP_ON_WRAP(STOP_ON_WRAP)) dut (
        .clk(clk), .reset_n(reset_n),
        .start_e(start_e), .pause_e(pause_e), .stop_e(stop_e),
        .clear_e(clear_e), .lap_e(lap_e), .wrap_in(wrap_in),
        .count_en(count_en), .clr_digits(clr_digits), .disp_hold(disp_hold),
        .running(running), .overflow(overflow), .state(state)
    );

    // clock
    always #5 clk = ~clk;

    // behavioural model: decide the single effective action, then apply it
    int       m_state, m_presc;
    bit       m_cnt, m_clr, m_hold, m_ovf, m_wrap;
    bit [4:0] m_hist, m_lv, m_e;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_state = S_IDLE; m_presc = 0; m_cnt = 0; m_clr = 0;
            m_hold = 0; m_ovf = 0; m_hist = '0;
        end else begin
            m_lv   = {clear_e, stop_e, pause_e, start_e, lap_e};
            m_e    = m_lv & ~m_hist;
            m_hist = m_lv;
            m_wrap = m_cnt && wrap_in;
            m_cnt  = 0;
            m_clr  = 0;
            if (m_wrap) m_ovf = 1;
            if (m_e[4]) begin
                m_state = S_IDLE; m_presc = 0; m_hold = 0; m_ovf = 0; m_clr = 1;
            end else if (m_state == S_IDLE) begin
                if (m_e[1]) begin m_state = S_RUN; m_presc = 0; end
            end else if (m_state == S_RUN) begin
                if (m_e[3] || (m_wrap && STOP_ON_WRAP != 0)) m_state = S_STOPPED;
                else if (m_e[2]) m_state = S_PAUSED;
                else begin
                    if (m_e[0]) m_hold = !m_hold;
                    m_presc = (m_presc + 1) % TICK_DIV;
                    m_cnt   = (m_presc == 0);
                end
            end else if (m_state == S_PAUSED) begin
                if (m_e[3]) m_state = S_STOPPED;
                else if (m_e[2] || m_e[1]) m_state = S_RUN;
                else if (m_e[0]) m_hold = !m_hold;
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    // scoreboard: every cycle against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("state", int'(state), m_state);
            chk("running", int'(running), int'(m_state == S_RUN));
            chk("count_en", int'(count_en), int'(m_cnt));
            chk("clr_digits", int'(clr_digits), int'(m_clr));
            chk("disp_hold", int'(disp_hold), int'(m_hold));
            chk("overflow", int'(overflow), int'(m_ovf));
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input bit [4:0] v);
        {clear_e, stop_e, pause_e, start_e, lap_e} = v;
    endtask

    task automatic press(input bit [4:0] v);
        set_btn(v);
        tick();
        set_btn(5'b0);
        tick();
    endtask

    task automatic wait_tick(output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (count_en) begin
                n = i;
                break;
            end
        end
        if (n < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_tick: no count_en within 20 cycles");
        end
    endtask

    localparam bit [4:0] B_CLR = 5'b10000, B_STOP = 5'b01000, B_PAUSE = 5'b00100,
                         B_START = 5'b00010, B_LAP = 5'b00001;

    int n, cnt;

    initial begin
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("reset_state", int'(state), 0);
        chk("reset_model_state", m_state, 0);
        reset_n = 1'b1;
        tick();

        // start -> running next cycle, ticks 4 cycles after the start edge
        set_btn(B_START);
        wait_tick(n);
        chk("start_to_tick", n - 1, 4);
        set_btn(5'b0);
        wait_tick(n);
        chk("tick_period", n, 4);

        // pause with prescaler at 2, hold 10 cycles, resume
        repeat (2) tick();
        set_btn(B_PAUSE);
        tick();
        set_btn(5'b0);
        chk("paused_state", int'(state), 2);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (count_en) cnt++;
            chk("paused_hold_state", int'(state), 2);
        end
        chk("paused_ticks", cnt, 0);
        set_btn(B_PAUSE);
        wait_tick(n);
        chk("resume_to_tick", n - 1, 2);
        set_btn(5'b0);
        tick();

        // start/pause/stop/clear together in RUN, held 5 more cycles
        set_btn(B_CLR | B_STOP | B_PAUSE | B_START);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (clr_digits) cnt++;
        end
        chk("multi_clr_pulses", cnt, 1);
        chk("multi_state", int'(state), 0);
        set_btn(5'b0);
        tick();

        // stop, then start/pause ignored, then clear
        press(B_START);
        press(B_STOP);
        chk("stopped_state", int'(state), 3);
        set_btn(B_START | B_PAUSE);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (count_en) cnt++;
        end
        chk("stopped_ticks", cnt, 0);
        chk("stopped_ignore", int'(state), 3);
        set_btn(B_CLR);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (clr_digits) cnt++;
        end
        chk("stop_clear_pulses", cnt, 1);
        chk("stop_clear_state", int'(state), 0);
        set_btn(5'b0);
        tick();

        // lap toggles hold while counting continues
        press(B_START);
        press(B_LAP);
        chk("lap_hold_on", int'(disp_hold), 1);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (count_en) cnt++;
        end
        chk("lap_ticks", cnt, 2);
        press(B_LAP);
        chk("lap_hold_off", int'(disp_hold), 0);
        press(B_LAP);
        press(B_CLR);
        chk("lap_clear_hold", int'(disp_hold), 0);
        chk("lap_clear_state", int'(state), 0);

        // wrap coincident with count_en
        press(B_START);
        wait_tick(n);
        wrap_in = 1'b1;
        tick();
        wrap_in = 1'b0;
        chk("wrap_overflow", int'(overflow), 1);
        chk("wrap_state", int'(state), 3);
        press(B_CLR);
        chk("wrap_clear_overflow", int'(overflow), 0);
        chk("wrap_clear_state", int'(state), 0);

        // asynchronous reset mid-RUN
        press(B_START);
        repeat (5) tick();
        #2 reset_n = 1'b0;
        #1;
        chk("areset_state", int'(state), 0);
        chk("areset_running", int'(running), 0);
        chk("areset_count_en", int'(count_en), 0);
        chk("areset_clr", int'(clr_digits), 0);
        chk("areset_hold", int'(disp_hold), 0);
        chk("areset_overflow", int'(overflow), 0);
        tick();
        reset_n = 1'b1;
        tick();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(0, 4) == 0) start_e = ~start_e;
            if ($urandom_range(0, 6) == 0) pause_e = ~pause_e;
            if ($urandom_range(0, 9) == 0) stop_e  = ~stop_e;
            if ($urandom_range(0, 14) == 0) clear_e = ~clear_e;
            if ($urandom_range(0, 5) == 0) lap_e   = ~lap_e;
            wrap_in = ($urandom_range(0, 3) == 0);
        end
        set_btn(5'b0);
        wrap_in = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
